// File: rtl/seg_scan_if.sv
// Bundle of display data inputs and scan outputs for seg_scan_driver.
// master = the producer of display data (and consumer of the scan pins),
// slave  = the scan driver itself.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 3
);
  logic [4*NUM_DIGITS-1:0] digits_bcd;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blink_phase;
  logic                    lzb_en;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              duan;
  logic [7:0]              duan1;
  logic                    frame_start;

  modport master (
    output digits_bcd, dp_mask, blank_mask, blink_mask, blink_phase, lzb_en, brightness,
    input  an, duan, duan1, frame_start
  );

  modport slave (
    input  digits_bcd, dp_mask, blank_mask, blink_mask, blink_phase, lzb_en, brightness,
    output an, duan, duan1, frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: NUM_DIGITS digits over one or two
// segment banks, frame-coherent snapshot of digit data, blank/blink/dp
// masks, leading-zero blanking, optional hex glyphs and PWM brightness
// with a one-clock dead time at the start of every scan slot.
module seg_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int NUM_BANKS  = 2,
  parameter int SCAN_DIV   = 100000,
  parameter int BRIGHT_W   = 3,
  parameter int HEX_EN     = 0
) (
  input logic        clk,
  input logic        rst,
  seg_scan_if.slave  bus
);

  localparam int SLOTS  = NUM_DIGITS / NUM_BANKS;
  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int SCAN_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  // Wide enough for (2^BRIGHT_W) * (SCAN_DIV-1) without overflow.
  localparam int PROD_W = CNT_W + BRIGHT_W + 2;

  if ((NUM_DIGITS % 2) != 0 || NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("seg_scan_driver: NUM_DIGITS must be even and within 2..16");
  end
  if (NUM_BANKS != 1 && NUM_BANKS != 2) begin : g_bad_banks
    $error("seg_scan_driver: NUM_BANKS must be 1 or 2");
  end
  if ((NUM_DIGITS % NUM_BANKS) != 0) begin : g_bad_split
    $error("seg_scan_driver: NUM_DIGITS must divide evenly over NUM_BANKS");
  end
  if (SCAN_DIV < 4) begin : g_bad_div
    $error("seg_scan_driver: SCAN_DIV must be at least 4");
  end

  // Segment pattern for one BCD/hex code (bit7 dp, 6..0 = a..g).
  function automatic logic [7:0] glyph(input logic [3:0] code);
    logic [7:0] g;
    case (code)
      4'd0:    g = 8'h7E;
      4'd1:    g = 8'h30;
      4'd2:    g = 8'h6D;
      4'd3:    g = 8'h79;
      4'd4:    g = 8'h33;
      4'd5:    g = 8'h5B;
      4'd6:    g = 8'h5F;
      4'd7:    g = 8'h70;
      4'd8:    g = 8'h7F;
      4'd9:    g = 8'h7B;
      4'd10:   g = (HEX_EN != 0) ? 8'h77 : 8'h01;
      4'd11:   g = (HEX_EN != 0) ? 8'h1F : 8'h01;
      4'd12:   g = (HEX_EN != 0) ? 8'h4E : 8'h01;
      4'd13:   g = (HEX_EN != 0) ? 8'h3D : 8'h01;
      4'd14:   g = (HEX_EN != 0) ? 8'h4F : 8'h01;
      4'd15:   g = (HEX_EN != 0) ? 8'h47 : 8'h01;
      default: g = 8'h01;
    endcase
    return g;
  endfunction

  logic [CNT_W-1:0]        slot_q, slot_d;
  logic [SCAN_W-1:0]       scan_q, scan_d;
  logic [4*NUM_DIGITS-1:0] dig_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              duan_q, duan_d;
  logic [7:0]              duan1_q, duan1_d;

  logic                    frame_start_s;
  logic [NUM_DIGITS-1:0]   lzb_s;
  logic [NUM_DIGITS-1:0]   dark_s;
  logic [7:0]              seg_s [NUM_DIGITS];
  logic [PROD_W-1:0]       prod_s;
  logic [PROD_W-1:0]       on_limit_s;
  logic                    active_s;
  logic [IDX_W-1:0]        idx0_s;
  logic [IDX_W-1:0]        idx1_s;

  // Frame start is held low while in reset so it only pulses on live frames.
  assign frame_start_s = ~rst & (slot_q == CNT_W'(0)) & (scan_q == SCAN_W'(0));

  // Digit lit on each bank in the current slot; bank 1 mirrors bank 0 when single-bank.
  assign idx0_s = IDX_W'(scan_q);
  assign idx1_s = (NUM_BANKS == 2) ? (IDX_W'(scan_q) + IDX_W'(SLOTS)) : IDX_W'(scan_q);

  // Prescaler and slot index: slot_cnt wraps at SCAN_DIV, scan_idx at SLOTS.
  always_comb begin
    slot_d = slot_q;
    scan_d = scan_q;
    if (slot_q == CNT_W'(SCAN_DIV - 1)) begin
      slot_d = CNT_W'(0);
      if (scan_q == SCAN_W'(SLOTS - 1)) begin
        scan_d = SCAN_W'(0);
      end else begin
        scan_d = scan_q + SCAN_W'(1);
      end
    end else begin
      slot_d = slot_q + CNT_W'(1);
      scan_d = scan_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= CNT_W'(0);
      scan_q <= SCAN_W'(0);
    end else begin
      slot_q <= slot_d;
      scan_q <= scan_d;
    end
  end

  // Frame snapshot of digit data, dp and blank masks, taken as the frame-start cycle ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q   <= {(4*NUM_DIGITS){1'b0}};
      dp_q    <= {NUM_DIGITS{1'b0}};
      blank_q <= {NUM_DIGITS{1'b0}};
    end else if (frame_start_s) begin
      dig_q   <= bus.digits_bcd;
      dp_q    <= bus.dp_mask;
      blank_q <= bus.blank_mask;
    end else begin
      dig_q   <= dig_q;
      dp_q    <= dp_q;
      blank_q <= blank_q;
    end
  end

  // Per-digit segment pattern after leading-zero, blank and blink suppression.
  always_comb begin
    logic [3:0] code;
    logic       lead_zero;
    code      = 4'd0;
    lead_zero = 1'b1;
    lzb_s     = {NUM_DIGITS{1'b0}};
    dark_s    = {NUM_DIGITS{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      code      = dig_q[4*i +: 4];
      lead_zero = lead_zero & (code == 4'd0);
      // The last digit always shows, so an all-zero value still reads "0".
      if (i < NUM_DIGITS - 1) begin
        lzb_s[i] = bus.lzb_en & lead_zero;
      end else begin
        lzb_s[i] = 1'b0;
      end
      dark_s[i] = blank_q[i] | (bus.blink_mask[i] & ~bus.blink_phase) | lzb_s[i];
      if (dark_s[i]) begin
        seg_s[i] = 8'h00;
      end else begin
        seg_s[i] = glyph(code) | {dp_q[i], 7'b000_0000};
      end
    end
  end

  // Brightness on-window: slot_cnt 0 is always dead time, then lit up to on_limit-1.
  always_comb begin
    prod_s     = (PROD_W'(bus.brightness) + PROD_W'(1)) * PROD_W'(SCAN_DIV - 1);
    on_limit_s = (prod_s >> BRIGHT_W) + PROD_W'(1);
    active_s   = (slot_q != CNT_W'(0)) && (PROD_W'(slot_q) < on_limit_s);
  end

  // Anode and segment bus values for the current slot.
  always_comb begin
    an_d    = {NUM_DIGITS{1'b0}};
    duan_d  = 8'h00;
    duan1_d = 8'h00;
    if (active_s) begin
      an_d[idx0_s] = 1'b1;
      duan_d       = seg_s[idx0_s];
      if (NUM_BANKS == 2) begin
        an_d[idx1_s] = 1'b1;
        duan1_d      = seg_s[idx1_s];
      end else begin
        duan1_d = 8'h00;
      end
    end else begin
      an_d    = {NUM_DIGITS{1'b0}};
      duan_d  = 8'h00;
      duan1_d = 8'h00;
    end
  end

  // Output registers: pins show the previous cycle's scan decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q    <= {NUM_DIGITS{1'b0}};
      duan_q  <= 8'h00;
      duan1_q <= 8'h00;
    end else begin
      an_q    <= an_d;
      duan_q  <= duan_d;
      duan1_q <= duan1_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.duan        = duan_q;
  assign bus.duan1       = duan1_q;
  assign bus.frame_start = frame_start_s;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (8 digits, 2 banks, SCAN_DIV=8, BRIGHT_W=3).
// Two instances differ only in HEX_EN and share all stimulus. A frame-level
// model predicts every output on every cycle; literal expectations pin it.
module tb_seg_scan_driver;
  localparam int ND = 8;
  localparam int SD = 8;
  localparam int BW = 3;
  localparam int FRAME = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digits_bcd  = 32'h0;
  logic [7:0]  dp_mask     = 8'h00;
  logic [7:0]  blank_mask  = 8'h00;
  logic [7:0]  blink_mask  = 8'h00;
  logic        blink_phase = 1'b1;
  logic        lzb_en      = 1'b0;
  logic [2:0]  brightness  = 3'd7;

  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) if0 ();
  seg_scan_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) if1 ();

  assign if0.digits_bcd = digits_bcd;   assign if1.digits_bcd = digits_bcd;
  assign if0.dp_mask = dp_mask;         assign if1.dp_mask = dp_mask;
  assign if0.blank_mask = blank_mask;   assign if1.blank_mask = blank_mask;
  assign if0.blink_mask = blink_mask;   assign if1.blink_mask = blink_mask;
  assign if0.blink_phase = blink_phase; assign if1.blink_phase = blink_phase;
  assign if0.lzb_en = lzb_en;           assign if1.lzb_en = lzb_en;
  assign if0.brightness = brightness;   assign if1.brightness = brightness;

  seg_scan_driver #(.NUM_DIGITS(ND), .NUM_BANKS(2), .SCAN_DIV(SD), .BRIGHT_W(BW), .HEX_EN(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  seg_scan_driver #(.NUM_DIGITS(ND), .NUM_BANKS(2), .SCAN_DIV(SD), .BRIGHT_W(BW), .HEX_EN(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  bit          prev_rst = 1'b1;
  int          m_pos    = 0;
  logic [31:0] snap_d   = 32'h0;
  logic [7:0]  snap_dp  = 8'h00;
  logic [7:0]  snap_bl  = 8'h00;
  logic [7:0]  nx_an = 8'h00, nx_a0 = 8'h00, nx_b0 = 8'h00, nx_a1 = 8'h00, nx_b1 = 8'h00;

  // Literal-expectation mailbox (stimulus writes the request, checker completes it)
  int          lit_req = 0;
  int          lit_done = 0;
  int          lit_kind = 0;
  int          lit_pos = 0;
  bit          lit_any = 1'b0;
  logic [7:0]  lit_an = 8'h00, lit_a0 = 8'h00, lit_b0 = 8'h00, lit_a1 = 8'h00;
  logic        lit_fs = 1'b0;
  int          lit_meas = 0;
  int          lit_expv = 0;
  string       lit_name = "";

  function automatic logic [7:0] glyph(input logic [3:0] c, input bit hex);
    case (c)
      4'd0: return 8'h7E;  4'd1: return 8'h30;  4'd2: return 8'h6D;  4'd3: return 8'h79;
      4'd4: return 8'h33;  4'd5: return 8'h5B;  4'd6: return 8'h5F;  4'd7: return 8'h70;
      4'd8: return 8'h7F;  4'd9: return 8'h7B;
      4'd10: return hex ? 8'h77 : 8'h01;  4'd11: return hex ? 8'h1F : 8'h01;
      4'd12: return hex ? 8'h4E : 8'h01;  4'd13: return hex ? 8'h3D : 8'h01;
      4'd14: return hex ? 8'h4F : 8'h01;  4'd15: return hex ? 8'h47 : 8'h01;
      default: return 8'h01;
    endcase
  endfunction

  // What digit i must show given the frame snapshot and the live masks.
  function automatic logic [7:0] digit_seg(input int i, input bit hex);
    bit lz;
    bit dark;
    lz = (lzb_en == 1'b1) && (i < ND - 1);
    for (int j = 0; j <= i; j++) begin
      if (snap_d[4*j +: 4] != 4'd0) lz = 1'b0;
    end
    dark = snap_bl[i] || (blink_mask[i] && !blink_phase) || lz;
    if (dark) return 8'h00;
    return glyph(snap_d[4*i +: 4], hex) | (snap_dp[i] ? 8'h80 : 8'h00);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t pos=%0d)", name, act, exp, $time, m_pos);
    end
  endtask

  // Single compare process: model prediction every cycle plus literal requests.
  always @(negedge clk) begin
    logic [7:0] e_an, e_a0, e_b0, e_a1, e_b1;
    int sc, s, onl;
    bit e_fs;
    if (prev_rst) begin
      e_an = 8'h00; e_a0 = 8'h00; e_b0 = 8'h00; e_a1 = 8'h00; e_b1 = 8'h00;
    end else begin
      e_an = nx_an; e_a0 = nx_a0; e_b0 = nx_b0; e_a1 = nx_a1; e_b1 = nx_b1;
    end
    chk("model_an", if0.an, e_an);
    chk("model_an_hex", if1.an, e_an);
    chk("model_duan", if0.duan, e_a0);
    chk("model_duan1", if0.duan1, e_b0);
    chk("model_duan_hex", if1.duan, e_a1);
    chk("model_duan1_hex", if1.duan1, e_b1);

    m_pos = prev_rst ? 0 : m_pos + 1;
    e_fs = !rst && ((m_pos % FRAME) == 0);
    chk("model_frame_start", if0.frame_start, e_fs);
    chk("model_frame_start_hex", if1.frame_start, e_fs);

    if (lit_req != lit_done && (lit_any || (!rst && m_pos == lit_pos))) begin
      case (lit_kind)
        0: begin
          chk({lit_name, "_an"}, if0.an, lit_an);
          chk({lit_name, "_duan"}, if0.duan, lit_a0);
          chk({lit_name, "_duan1"}, if0.duan1, lit_b0);
          chk({lit_name, "_duan_hex"}, if1.duan, lit_a1);
        end
        1: chk(lit_name, if0.frame_start, lit_fs);
        2: chk(lit_name, lit_meas, lit_expv);
        default: chk({lit_name, "_kind"}, lit_kind, 0);
      endcase
      lit_done = lit_req;
    end

    // Prediction for the next cycle's registered outputs.
    nx_an = 8'h00; nx_a0 = 8'h00; nx_b0 = 8'h00; nx_a1 = 8'h00; nx_b1 = 8'h00;
    if (!rst) begin
      sc  = m_pos % SD;
      s   = (m_pos / SD) % (ND / 2);
      onl = 1 + (((int'(brightness) + 1) * (SD - 1)) >> BW);
      if (sc >= 1 && sc < onl) begin
        nx_an = 8'(1 << s) | 8'(1 << (s + ND / 2));
        nx_a0 = digit_seg(s, 1'b0);
        nx_b0 = digit_seg(s + ND / 2, 1'b0);
        nx_a1 = digit_seg(s, 1'b1);
        nx_b1 = digit_seg(s + ND / 2, 1'b1);
      end
      if ((m_pos % FRAME) == 0) begin
        snap_d  = digits_bcd;
        snap_dp = dp_mask;
        snap_bl = blank_mask;
      end
    end
    prev_rst = rst;
  end

  task automatic wait_lit();
    int guard = 0;
    while (lit_done != lit_req) begin
      @(negedge clk); #1;
      guard++;
      if (guard > 200) begin
        $display("FAIL lit_timeout %s: waited %0d cycles, required completion", lit_name, guard);
        $fatal(1, "literal expectation never reached");
      end
    end
  endtask

  function automatic int tgt(input int rel);
    int t;
    t = m_pos - (m_pos % FRAME) + rel;
    if (t <= m_pos) t += FRAME;
    return t;
  endfunction

  task automatic lit_out(input string name, input int pos, input bit any,
                         input logic [7:0] an, input logic [7:0] a0,
                         input logic [7:0] b0, input logic [7:0] a1);
    lit_name = name; lit_kind = 0; lit_pos = pos; lit_any = any;
    lit_an = an; lit_a0 = a0; lit_b0 = b0; lit_a1 = a1;
    lit_req++;
    wait_lit();
  endtask

  task automatic at(input string name, input int rel, input logic [7:0] an,
                    input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1);
    lit_out(name, tgt(rel), 1'b0, an, a0, b0, a1);
  endtask

  task automatic fs_lit(input string name, input int pos, input bit any, input logic v);
    lit_name = name; lit_kind = 1; lit_pos = pos; lit_any = any; lit_fs = v;
    lit_req++;
    wait_lit();
  endtask

  task automatic meas(input string name, input int m, input int e);
    lit_name = name; lit_kind = 2; lit_any = 1'b1; lit_meas = m; lit_expv = e;
    lit_req++;
    wait_lit();
  endtask

  task automatic drive_slot();
    @(posedge clk); #1;
  endtask

  task automatic next_frame();
    int guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
      if (guard > 80) begin
        $display("FAIL next_frame_timeout: waited %0d cycles, required frame boundary", guard);
        $fatal(1, "frame boundary not reached");
      end
    end while ((m_pos % FRAME) != 1);
  endtask

  task automatic count_active(output int cnt);
    cnt = 0;
    repeat (FRAME) begin
      @(negedge clk); #1;
      if (if0.an != 8'h00) cnt++;
    end
  endtask

  initial begin
    int cnt;
    digits_bcd = 32'h87654321;
    brightness = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    // 1. Reset hold and frame_start cadence
    lit_out("reset_hold", 0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    fs_lit("reset_fs", 0, 1'b1, 1'b0);
    drive_slot(); rst = 1'b0;
    fs_lit("fs_first_cycle", 0, 1'b0, 1'b1);
    fs_lit("fs_second_cycle", 1, 1'b0, 1'b0);
    fs_lit("fs_frame1", 32, 1'b0, 1'b1);
    fs_lit("fs_frame2", 64, 1'b0, 1'b1);
    // 2. Basic scan, full brightness
    at("slot0", 4, 8'h11, 8'h30, 8'h5B, 8'h30);
    at("slot0_last", 8, 8'h11, 8'h30, 8'h5B, 8'h30);
    at("slot0_dead", 9, 8'h00, 8'h00, 8'h00, 8'h00);
    at("slot3", 28, 8'h88, 8'h33, 8'h7F, 8'h33);
    // 3. Brightness sweep
    drive_slot(); brightness = 3'd3;
    at("bright3_on", 12, 8'h22, 8'h6D, 8'h5F, 8'h6D);
    at("bright3_off", 13, 8'h00, 8'h00, 8'h00, 8'h00);
    count_active(cnt);
    meas("bright3_count", cnt, 12);
    drive_slot(); brightness = 3'd0;
    repeat (2) @(negedge clk);
    #1;
    count_active(cnt);
    meas("bright0_count", cnt, 0);
    drive_slot(); brightness = 3'd7;
    // 4. Leading-zero blanking
    drive_slot(); lzb_en = 1'b1; digits_bcd = 32'h0;
    next_frame();
    at("lzb_zero_s0", 4, 8'h11, 8'h00, 8'h00, 8'h00);
    at("lzb_zero_s3", 28, 8'h88, 8'h00, 8'h7E, 8'h00);
    drive_slot(); digits_bcd = 32'h0000_0100;
    next_frame();
    at("lzb_s0", 4, 8'h11, 8'h00, 8'h7E, 8'h00);
    at("lzb_s1", 12, 8'h22, 8'h00, 8'h7E, 8'h00);
    at("lzb_s2", 20, 8'h44, 8'h30, 8'h7E, 8'h30);
    at("lzb_s3", 28, 8'h88, 8'h7E, 8'h7E, 8'h7E);
    drive_slot(); lzb_en = 1'b0; digits_bcd = 32'h87654321;
    // 5. Mid-frame change is held until the next frame
    next_frame();
    at("snap_pre", 18, 8'h44, 8'h79, 8'h70, 8'h79);
    drive_slot(); digits_bcd = 32'h99999999;
    at("snap_hold_s2", 20, 8'h44, 8'h79, 8'h70, 8'h79);
    at("snap_hold_s3", 28, 8'h88, 8'h33, 8'h7F, 8'h33);
    at("snap_new_s0", 4, 8'h11, 8'h7B, 8'h7B, 8'h7B);
    // 6. Blink, dp and hex decode
    drive_slot(); digits_bcd = 32'h87654321; blink_mask = 8'h03; blink_phase = 1'b0;
    next_frame();
    at("blink_s0", 4, 8'h11, 8'h00, 8'h5B, 8'h00);
    at("blink_s1", 12, 8'h22, 8'h00, 8'h5F, 8'h00);
    drive_slot(); blink_phase = 1'b1;
    at("blink_restore", 4, 8'h11, 8'h30, 8'h5B, 8'h30);
    drive_slot(); blink_mask = 8'h00; digits_bcd = 32'h87654311; dp_mask = 8'h02;
    next_frame();
    at("dp_digit1", 12, 8'h22, 8'hB0, 8'h5F, 8'hB0);
    drive_slot(); dp_mask = 8'h00; digits_bcd = 32'h876543A1;
    next_frame();
    at("hex_a", 12, 8'h22, 8'h01, 8'h5F, 8'h77);
    // 7. Reset mid-frame, then fresh snapshot
    at("pre_reset", 14, 8'h22, 8'h01, 8'h5F, 8'h77);
    drive_slot(); rst = 1'b1; digits_bcd = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    lit_out("mid_reset", 0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    fs_lit("mid_reset_fs", 0, 1'b1, 1'b0);
    drive_slot(); rst = 1'b0;
    fs_lit("fs_after_reset", 0, 1'b0, 1'b1);
    at("after_reset_s0", 4, 8'h11, 8'h7F, 8'h33, 8'h7F);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
